// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side pointer and flag controller of the asynchronous FIFO. This runs
// entirely in the read clock domain.
//   - Brings the write-domain Gray write pointer across through a
//     SYNC_STAGES-deep flop chain.
//   - Keeps the binary and Gray read pointers and drives the memory read
//     address.
//   - Hands fifo_empty its two comparison operands (synchronized write pointer
//     and next Gray read pointer), then registers its combinational verdict
//     as the empty flag.
//
// Optional feature: define RD_LEVEL_EN to add the rd_level occupancy output.
//
// Parameters
//   FIFO_DEPTH   number of entries, power of two >= 4
//   SYNC_STAGES  write-pointer synchronizer depth, 2..4
//
// Ports
//   clk               in   read-domain clock
//   rst               in   synchronous active-high reset
//   rd_en             in   read request from the consumer
//   wr_ptr_gray       in   Gray write pointer, asynchronous to clk
//   empty_in          in   combinational empty result from fifo_empty
//   wr_ptr_gray_sync  out  last synchronizer stage, to fifo_empty
//   rd_ptr_gray_next  out  combinational next Gray read pointer, to fifo_empty
//   rd_ptr_gray       out  registered Gray read pointer, to the write domain
//   rd_addr           out  memory read address
//   empty             out  registered empty flag
//   rd_valid          out  read data valid at the memory output
//   underflow         out  one-cycle pulse on a rejected read
//   rd_level          out  (RD_LEVEL_EN only) conservative occupancy
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [PTR_W:0]   wr_ptr_gray,
    input  logic             empty_in,
    output logic [PTR_W:0]   wr_ptr_gray_sync,
    output logic [PTR_W:0]   rd_ptr_gray_next,
    output logic [PTR_W:0]   rd_ptr_gray,
    output logic [PTR_W-1:0] rd_addr,
    output logic             empty,
`ifdef RD_LEVEL_EN
    output logic [PTR_W:0]   rd_level,
`endif
    output logic             rd_valid,
    output logic             underflow
);

    // -------------------------------------------------------------------------
    // Write-pointer synchronizer: plain flop chain, nothing between stages so
    // each stage has a full cycle to resolve metastability.
    // -------------------------------------------------------------------------
    logic [PTR_W:0] sync_reg [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= '0;
                    else     sync_reg[gi] <= wr_ptr_gray;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= '0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign wr_ptr_gray_sync = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Read pointer
    // -------------------------------------------------------------------------
    logic [PTR_W:0] rd_bin_reg;
    logic [PTR_W:0] rd_gray_reg;
    logic [PTR_W:0] rd_bin_next;
    logic           empty_reg;
    logic           rd_valid_reg;
    logic           underflow_reg;
    logic           rd_inc;

    // Accept against the registered flag only: empty_in already reflects this
    // cycle's read, so using it here would form a combinational loop.
    assign rd_inc      = rd_en & ~empty_reg;
    // Extra MSB lets the pointer wrap at 2*FIFO_DEPTH, which is what lets
    // fifo_empty tell full from empty.
    assign rd_bin_next = rd_bin_reg + (PTR_W+1)'(rd_inc);
    assign rd_ptr_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bin_reg    <= '0;
            rd_gray_reg   <= '0;
            empty_reg     <= 1'b1;
            rd_valid_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            rd_bin_reg    <= rd_bin_next;
            rd_gray_reg   <= rd_ptr_gray_next;
            empty_reg     <= empty_in;
            rd_valid_reg  <= rd_inc;
            underflow_reg <= rd_en & empty_reg;
        end
    end

    assign rd_ptr_gray = rd_gray_reg;
    assign rd_addr     = rd_bin_reg[PTR_W-1:0];
    assign empty       = empty_reg;
    assign rd_valid    = rd_valid_reg;
    assign underflow   = underflow_reg;

`ifdef RD_LEVEL_EN
    // -------------------------------------------------------------------------
    // Occupancy: synchronized write pointer (stale, hence an under-estimate)
    // converted to binary, minus the read pointer after this cycle's read.
    // -------------------------------------------------------------------------
    logic [PTR_W:0] wr_sync_bin;
    logic [PTR_W:0] rd_level_reg;

    generate
        for (genvar gi = 0; gi <= PTR_W; gi++) begin : g_g2b
            assign wr_sync_bin[gi] = ^wr_ptr_gray_sync[PTR_W:gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) rd_level_reg <= '0;
        else     rd_level_reg <= wr_sync_bin - rd_bin_next;
    end

    assign rd_level = rd_level_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Directed bench for fifo_rd_ctrl with FIFO_DEPTH=16, SYNC_STAGES=2. The
// fifo_empty block is stood in for by its defining equation (synchronized
// write pointer equals next Gray read pointer). The write side is driven
// directly as a Gray count of entries written.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    logic [4:0] wr_ptr_gray;
    logic       empty_in;
    logic [4:0] wr_ptr_gray_sync;
    logic [4:0] rd_ptr_gray_next;
    logic [4:0] rd_ptr_gray;
    logic [3:0] rd_addr;
    logic       empty;
    logic       rd_valid;
    logic       underflow;
`ifdef RD_LEVEL_EN
    logic [4:0] rd_level;
`endif

    int errors = 0;
    int checks = 0;

    fifo_rd_ctrl #(
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rd_en            (rd_en),
        .wr_ptr_gray      (wr_ptr_gray),
        .empty_in         (empty_in),
        .wr_ptr_gray_sync (wr_ptr_gray_sync),
        .rd_ptr_gray_next (rd_ptr_gray_next),
        .rd_ptr_gray      (rd_ptr_gray),
        .rd_addr          (rd_addr),
        .empty            (empty),
`ifdef RD_LEVEL_EN
        .rd_level         (rd_level),
`endif
        .rd_valid         (rd_valid),
        .underflow        (underflow)
    );

    // fifo_empty stand-in
    assign empty_in = (wr_ptr_gray_sync == rd_ptr_gray_next);

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled and inputs changed 1 ns
    // after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("[%0t] %s ok: observed=%0h", $time, tag, obs);
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] bin2gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    initial begin
        int   wr_cnt;
        int   rd_seen;
        int   waited;
        logic [4:0] prev_gray;
        logic [3:0] prev_addr;
        logic seen_addr_wrap;
        logic seen_gray_wrap;

        // ---------------- Reset with rd_en held high ----------------
        rst         = 1'b1;
        rd_en       = 1'b1;
        wr_ptr_gray = 5'd0;
        step();
        check("rst1_underflow", underflow, 0);
        step();
        check("rst_empty",      empty, 1);
        check("rst_addr",       rd_addr, 0);
        check("rst_gray",       rd_ptr_gray, 0);
        check("rst_valid",      rd_valid, 0);
        check("rst2_underflow", underflow, 0);

        // ---------------- Underflow: empty, rd_en for 3 cycles ----------------
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("uf%0d_underflow", i), underflow, 1);
            check($sformatf("uf%0d_gray", i),      rd_ptr_gray, 0);
            check($sformatf("uf%0d_valid", i),     rd_valid, 0);
        end

        // ---------------- Write visibility: one entry ----------------
        wr_ptr_gray = bin2gray(1);
        step();
        check("wv1_empty", empty, 1);
        step();
        check("wv2_empty", empty, 1);
        step();
        check("wv3_empty", empty, 0);
        check("wv3_addr",  rd_addr, 0);
        step();
        check("acc_addr",  rd_addr, 1);
        check("acc_gray",  rd_ptr_gray, 5'b00001);
        check("acc_valid", rd_valid, 1);
        check("acc_empty", empty, 1);
        step();
        check("post_valid", rd_valid, 0);
        check("post_addr",  rd_addr, 1);
        check("post_uf",    underflow, 1);

        // ---------------- Wrap-around: 40 more entries streamed ----------------
        wr_cnt         = 1;
        rd_seen        = 0;
        prev_gray      = rd_ptr_gray;
        prev_addr      = rd_addr;
        seen_addr_wrap = 1'b0;
        seen_gray_wrap = 1'b0;
        for (int cyc = 0; cyc < 400 && rd_seen < 40; cyc++) begin
            // keep occupancy (as known to the bench) within FIFO_DEPTH
            if (wr_cnt < 41 && (wr_cnt - 1 - rd_seen) < 16) wr_cnt++;
            wr_ptr_gray = bin2gray(wr_cnt);
            step();
            if (rd_valid) rd_seen++;
            check("gray_hamming", ($countones(prev_gray ^ rd_ptr_gray) <= 1), 1);
            if (prev_addr == 4'd15 && rd_addr == 4'd0)        seen_addr_wrap = 1'b1;
            if (prev_gray == 5'b10000 && rd_ptr_gray == 5'b0) seen_gray_wrap = 1'b1;
            prev_gray = rd_ptr_gray;
            prev_addr = rd_addr;
        end
        rd_en = 1'b0;
        check("wrap_reads",     rd_seen, 40);
        check("wrap_addr_seen", seen_addr_wrap, 1);
        check("wrap_gray_seen", seen_gray_wrap, 1);
        check("wrap_end_gray",  rd_ptr_gray, 5'b01101);
        check("wrap_end_addr",  rd_addr, 9);
        step();
        check("wrap_end_empty", empty, 1);

        // ---------------- Reset mid-stream at rd_bin=9 ----------------
        wr_cnt      = 43;
        wr_ptr_gray = bin2gray(wr_cnt);
        waited      = 0;
        while (empty !== 1'b0 && waited < 10) begin
            step();
            waited++;
        end
        check("mid_not_empty", empty, 0);
        check("mid_addr",      rd_addr, 9);
        rst         = 1'b1;
        rd_en       = 1'b1;
        wr_ptr_gray = 5'd0;
        step();
        check("mid_rst_addr",  rd_addr, 0);
        check("mid_rst_gray",  rd_ptr_gray, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_uf",    underflow, 0);
        rst   = 1'b0;
        rd_en = 1'b0;
        step();
        check("mid_after_empty", empty, 1);
        check("mid_after_addr",  rd_addr, 0);

`ifdef RD_LEVEL_EN
        // ---------------- Level: 10 written, 3 read ----------------
        wr_ptr_gray = bin2gray(10);
        waited      = 0;
        while (empty !== 1'b0 && waited < 10) begin
            step();
            waited++;
        end
        check("lvl_not_empty", empty, 0);
        rd_en   = 1'b1;
        rd_seen = 0;
        for (int cyc = 0; cyc < 20 && rd_seen < 3; cyc++) begin
            if (rd_seen == 2 && !empty) rd_en = 1'b1;
            step();
            if (rd_valid) rd_seen++;
            if (rd_seen >= 3) rd_en = 1'b0;
        end
        rd_en = 1'b0;
        check("lvl_reads", rd_seen, 3);
        step();
        step();
        check("lvl_7", rd_level, 7);

        // ---------------- Level: full at 16 ----------------
        rst         = 1'b1;
        wr_ptr_gray = 5'd0;
        step();
        check("lvl_rst", rd_level, 0);
        rst         = 1'b0;
        wr_ptr_gray = bin2gray(16);
        for (int i = 0; i < 4; i++) step();
        check("lvl_16", rd_level, 16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side pointer and flag controller of the async FIFO, in the read clock domain.
- Synchronizes the write-domain Gray write pointer.
- Maintains the binary and Gray read pointers and drives the memory read address.
- Feeds fifo_empty its two comparison inputs (synchronized write pointer, next Gray read pointer), then registers fifo_empty's combinational result into the FIFO's empty flag.

Parameters:
- FIFO_DEPTH, 16, number of entries; must be a power of two ≥ 4. PTR_W = $clog2(FIFO_DEPTH).
- SYNC_STAGES, 2, flops in the write-pointer synchronizer chain; legal range 2–4.

Ports:
- clk  input  1  read-domain clock.
- rst  input  1  synchronous, active-high reset.
- rd_en  input  1  read request from consumer.
- wr_ptr_gray  input  PTR_W+1  Gray write pointer from write domain (asynchronous to clk).
- empty_in  input  1  combinational empty result from fifo_empty.
- wr_ptr_gray_sync  output  PTR_W+1  last synchronizer stage; to fifo_empty.
- rd_ptr_gray_next  output  PTR_W+1  combinational next Gray read pointer; to fifo_empty.
- rd_ptr_gray  output  PTR_W+1  registered Gray read pointer; to write-domain synchronizer.
- rd_addr  output  PTR_W  memory read address.
- empty  output  1  registered empty flag.
- rd_valid  output  1  read data valid at memory output.
- underflow  output  1  one-cycle pulse on a rejected read.

Behaviour:
- All state updates on rising clk. rst is synchronous, active-high. rst overrides all other inputs in the same cycle.
- Reset values:
  - sync chain = 0, wr_ptr_gray_sync = 0
  - rd_bin = 0, rd_ptr_gray = 0, rd_addr = 0
  - empty = 1, rd_valid = 0, underflow = 0
- Synchronizer: wr_ptr_gray passes through SYNC_STAGES flops. No logic between stages. Output is the last stage.
- Read accept: rd_inc = rd_en & ~empty. Accept uses the registered empty, never empty_in.
- Next pointer, combinational:
  - rd_bin_next = rd_bin + rd_inc, modulo 2^(PTR_W+1); wraps FIFO_DEPTH*2-1 → 0.
  - rd_ptr_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
- Pointer update every cycle: rd_bin <= rd_bin_next; rd_ptr_gray <= rd_ptr_gray_next.
- rd_addr = rd_bin[PTR_W-1:0], driven from the register (no combinational path from rd_en).
- Empty flag:
  - empty <= empty_in each cycle.
  - The read that consumes the last entry asserts empty on the next cycle, with no bubble.
  - A write becomes visible SYNC_STAGES+1 cycles after wr_ptr_gray changes.
- rd_valid <= rd_inc. Memory is synchronous-read, so data is valid one cycle after accept.
- underflow <= rd_en & empty. Pulses one cycle and is not sticky. Pointers are unchanged on an underflow.
- Simultaneous events:
  - A read on the same cycle the synchronized write pointer advances is accepted only if the registered empty = 0.
  - The new write is counted via empty_in for the following cycle.
- Mid-operation reset: all pointers and flags return to reset values next edge. In-flight rd_valid is dropped.
- Gray output invariant: rd_ptr_gray changes by at most one bit per cycle.

Optional Feature:
Macro RD_LEVEL_EN.
- Defined:
  - Adds output rd_level [PTR_W:0], registered, reset 0.
  - Value: Gray-to-binary of wr_ptr_gray_sync minus rd_bin_next, modulo 2^(PTR_W+1).
  - It is a conservative (under-estimated) occupancy, range 0..FIFO_DEPTH.
- Not defined: port and conversion logic are absent. All other behaviour is identical.

Test Plan:
Bench instantiates fifo_empty in loop with this block; FIFO_DEPTH=16, SYNC_STAGES=2.
- Reset: rst=1 for 2 cycles with rd_en=1 → empty=1, rd_addr=0, rd_ptr_gray=0, rd_valid=0, underflow=0. Underflow pulses only after rst drops.
- Write visibility: wr_ptr_gray 0→1 (1 entry) → empty falls exactly 3 cycles later. rd_en held 1 → one accept, rd_addr 0→1, rd_valid=1 one cycle after, empty=1 the cycle after the accept.
- Underflow: empty=1, rd_en=1 for 3 cycles → underflow high 3 cycles, rd_bin unchanged, rd_valid=0.
- Wrap-around: write and read 40 entries continuously → rd_addr wraps 15→0, rd_ptr_gray wraps 5'b10000→5'b00000. Every rd_ptr_gray transition has Hamming distance ≤1.
- Reset mid-stream: rst at rd_bin=9 with rd_en=1 → next cycle rd_bin=0, empty=1, rd_valid=0.
- RD_LEVEL_EN: wr_ptr_gray for 10 entries written, 3 read → rd_level=7 after synchronizer settles. Full at 16 entries → rd_level=16.
